// File: rtl/sram_pkg.sv
// Shared types and constants for the on-chip stand-in of the external
// 256Kx16 async SRAM.
//   sram_resp_state_t : pin-cycle tracker states
//   SRAM_ADDR_W/SRAM_DATA_W : pin widths of the emulated part
//   SRAM_CNT_W : width of the optional statistics counters
//   sat_inc() : saturating increment for those counters
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEL   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } sram_resp_state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [SRAM_CNT_W-1:0] sat_inc(input logic [SRAM_CNT_W-1:0] v);
        return (v == {SRAM_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// Single-port read-first RAM backing the SRAM responder; shaped so that
// synthesis maps it onto block RAM.
// Ports:
//   clk      clock
//   reset    synchronous active-high; clears only the output register
//   we_i     write strobe for idx_i/wdata_i
//   idx_i    word index
//   wdata_i  write data
//   rdata_o  registered read data (contents before any same-cycle write)
module sram_resp_mem #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [0:(1<<IDX_W)-1];

    // Array write kept free of reset so it stays a pure RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // Output register with sync reset, as block RAM output latches allow.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem[idx_i];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Synthesizable stand-in for an external 256Kx16 async SRAM. Sits on the
// pin side of the SRAM controller, in the same clock domain, and answers
// its cycles from on-chip RAM. Upper address bits alias onto the
// 2**MEM_DEPTH_LOG2 words held on-chip.
// Optional feature: define SRAM_RESP_STATS_EN to add wr_count/rd_count.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   address_pins          address from controller
//   data_pins_in          write data from controller
//   data_pins_out         read data to controller (registered)
//   data_oe               high while the responder drives the bus
//   cs_n, oe_n, we_n      active-low chip select / output enable / write enable
//   protocol_err          sticky: OE and WE both low under CS
//   wr_count, rd_count    (SRAM_RESP_STATS_EN) saturating commit/read counters
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W         = SRAM_ADDR_W,
    parameter int DATA_W         = SRAM_DATA_W,
    parameter int MEM_DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address_pins,
    input  logic [DATA_W-1:0]     data_pins_in,
    output logic [DATA_W-1:0]     data_pins_out,
    output logic                  data_oe,
    input  logic                  cs_n,
    input  logic                  oe_n,
    input  logic                  we_n,
    output logic                  protocol_err
`ifdef SRAM_RESP_STATS_EN
    ,
    output logic [SRAM_CNT_W-1:0] wr_count,
    output logic [SRAM_CNT_W-1:0] rd_count
`endif
);

    sram_resp_state_t state_q, state_d;
    logic             prev_we_n_q;
    logic             err_q, err_d;
    logic             commit;
    logic             contention;

    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic                      unused_addr_hi;

    assign idx            = address_pins[MEM_DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^address_pins[ADDR_W-1:MEM_DEPTH_LOG2];

    assign contention = !cs_n && !oe_n && !we_n;

    // One commit per WE strobe: only the falling edge of we_n counts, and
    // never while OE is also low or reset is asserted.
    assign commit = !reset && !cs_n && !we_n && prev_we_n_q && oe_n;

    assign data_oe = !reset && !cs_n && !oe_n && we_n;

    sram_resp_mem #(
        .DATA_W (DATA_W),
        .IDX_W  (MEM_DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (commit),
        .idx_i   (idx),
        .wdata_i (data_pins_in),
        .rdata_o (data_pins_out)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q || contention;
        if (cs_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                // CS and WE may fall together, so IDLE can jump straight to WRITE.
                ST_IDLE:  state_d = commit ? ST_WRITE : ST_SEL;
                ST_SEL: begin
                    if (commit)              state_d = ST_WRITE;
                    else if (!oe_n && we_n)  state_d = ST_READ;
                end
                ST_WRITE: if (we_n) state_d = ST_SEL;
                ST_READ:  if (oe_n) state_d = ST_SEL;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prev_we_n_q <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_we_n_q <= we_n;
            err_q       <= err_d;
        end
    end

    assign protocol_err = err_q;

`ifdef SRAM_RESP_STATS_EN
    logic                  prev_oe_n_q;
    logic [SRAM_CNT_W-1:0] wr_cnt_q, rd_cnt_q;
    logic                  rd_start;

    assign rd_start = !cs_n && we_n && prev_oe_n_q && !oe_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_oe_n_q <= 1'b1;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            prev_oe_n_q <= oe_n;
            if (commit)   wr_cnt_q <= sat_inc(wr_cnt_q);
            if (rd_start) rd_cnt_q <= sat_inc(rd_cnt_q);
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`endif

endmodule
